// File: rtl/hier_node_dispatch.sv
// Tree node: routes upstream requests to one of NUM_CHILDREN children, tracks per-child
// in-flight counts, and merges child responses upstream via a round-robin arbiter into a register.
module hier_node_dispatch #(
  parameter  int NUM_CHILDREN    = 5,
  parameter  int DATA_W          = 32,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int IDX_W           = (NUM_CHILDREN == 1) ? 1 : $clog2(NUM_CHILDREN),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [IDX_W-1:0]               req_child,
  input  logic [DATA_W-1:0]              req_data,
  output logic [NUM_CHILDREN-1:0]        c_req_valid,
  input  logic [NUM_CHILDREN-1:0]        c_req_ready,
  output logic [DATA_W-1:0]              c_req_data,
  input  logic [NUM_CHILDREN-1:0]        c_rsp_valid,
  output logic [NUM_CHILDREN-1:0]        c_rsp_ready,
  input  logic [NUM_CHILDREN*DATA_W-1:0] c_rsp_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [IDX_W-1:0]               rsp_child,
  output logic [DATA_W-1:0]              rsp_data,
  output logic                           err_bad_idx,
  output logic                           err_unexp_rsp
);

  localparam logic [IDX_W:0]   NUM_LIMIT = (IDX_W + 1)'(NUM_CHILDREN);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHILDREN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]        cnt_q [NUM_CHILDREN];
  logic [NUM_CHILDREN-1:0] full, cnt_zero, req_sel, req_hs, rsp_hs;
  logic                    idx_valid;

  logic                    load_en;
  logic                    gnt_found;
  logic                    gnt_valid;
  logic [IDX_W-1:0]        gnt_idx;
  logic [DATA_W-1:0]       gnt_data;

  logic                    rsp_valid_q;
  logic [IDX_W-1:0]        rsp_child_q;
  logic [DATA_W-1:0]       rsp_data_q;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic                    err_bad_idx_q, err_unexp_rsp_q;

  assign idx_valid  = ({1'b0, req_child} < NUM_LIMIT);
  assign c_req_data = req_data;
  // Out-of-range indices are swallowed so a bad request never stalls upstream.
  assign req_ready  = idx_valid ? |(req_sel & c_req_ready & ~full) : 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_CHILDREN; gi++) begin : g_child
      assign full[gi]        = (cnt_q[gi] == CNT_MAX);
      assign cnt_zero[gi]    = (cnt_q[gi] == '0);
      assign req_sel[gi]     = (req_child == IDX_W'(gi));
      assign c_req_valid[gi] = req_valid & req_sel[gi] & ~full[gi];
      assign req_hs[gi]      = c_req_valid[gi] & c_req_ready[gi];
      assign rsp_hs[gi]      = c_rsp_valid[gi] & c_rsp_ready[gi];
      assign c_rsp_ready[gi] = gnt_valid & (gnt_idx == IDX_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q[gi] <= '0;
        end else if (req_hs[gi] && !rsp_hs[gi]) begin
          cnt_q[gi] <= cnt_q[gi] + CNT_W'(1);
        end else if (rsp_hs[gi] && !req_hs[gi] && !cnt_zero[gi]) begin
          cnt_q[gi] <= cnt_q[gi] - CNT_W'(1);
        end
      end
    end
  endgenerate

  assign load_en   = ~rsp_valid_q | rsp_ready;
  assign gnt_valid = load_en & gnt_found;

  // Pass 1 picks the lowest requester overall (wrap-around case); pass 2 overrides it
  // with the lowest requester at or above the pointer when one exists.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = NUM_CHILDREN - 1; i >= 0; i--) begin
      if (c_rsp_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(i);
      end
    end
    for (int i = NUM_CHILDREN - 1; i >= 0; i--) begin
      if (c_rsp_valid[i] && (IDX_W'(i) >= ptr_q)) begin
        gnt_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        gnt_data = c_rsp_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q     <= 1'b0;
      rsp_child_q     <= '0;
      rsp_data_q      <= '0;
      ptr_q           <= '0;
      err_bad_idx_q   <= 1'b0;
      err_unexp_rsp_q <= 1'b0;
    end else begin
      err_bad_idx_q   <= req_valid & ~idx_valid;
      err_unexp_rsp_q <= |(rsp_hs & cnt_zero);
      if (load_en) begin
        rsp_valid_q <= gnt_found;
        if (gnt_found) begin
          rsp_child_q <= gnt_idx;
          rsp_data_q  <= gnt_data;
          ptr_q       <= ptr_d;
        end
      end
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_child     = rsp_child_q;
  assign rsp_data      = rsp_data_q;
  assign err_bad_idx   = err_bad_idx_q;
  assign err_unexp_rsp = err_unexp_rsp_q;

endmodule

// File: tb/tb_hier_node_dispatch.sv
// Directed bench for hier_node_dispatch: request-path checks inline, upstream responses
// checked by a negedge monitor against a queue of hand-computed expectations.
module tb_hier_node_dispatch;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int IW = 3;

  logic            clk, rst_n;
  logic            req_valid, req_ready;
  logic [IW-1:0]   req_child;
  logic [DW-1:0]   req_data;
  logic [N-1:0]    c_req_valid, c_req_ready;
  logic [DW-1:0]   c_req_data;
  logic [N-1:0]    c_rsp_valid, c_rsp_ready;
  logic [N*DW-1:0] c_rsp_data;
  logic            rsp_valid, rsp_ready;
  logic [IW-1:0]   rsp_child;
  logic [DW-1:0]   rsp_data;
  logic            err_bad_idx, err_unexp_rsp;
  logic [DW-1:0]   child_data [N];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [IW-1:0] child;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t exp_q[$];
  rsp_t exp_e;

  hier_node_dispatch #(.NUM_CHILDREN(N), .DATA_W(DW), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_child(req_child), .req_data(req_data),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_data(c_req_data),
    .c_rsp_valid(c_rsp_valid), .c_rsp_ready(c_rsp_ready), .c_rsp_data(c_rsp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_child(rsp_child), .rsp_data(rsp_data),
    .err_bad_idx(err_bad_idx), .err_unexp_rsp(err_unexp_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    c_rsp_data = '0;
    for (int i = 0; i < N; i++) c_rsp_data[i*DW +: DW] = child_data[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input int child, input logic [DW-1:0] data);
    rsp_t e;
    e.child = IW'(child);
    e.data  = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every completed upstream handshake is one transaction.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got child %0d data %h, required none", rsp_child, rsp_data);
      end else begin
        exp_e = exp_q.pop_front();
        if (exp_e !== {rsp_child, rsp_data}) begin
          errors++;
          $display("FAIL rsp_txn: got child %0d data %h, required child %0d data %h",
                   rsp_child, rsp_data, exp_e.child, exp_e.data);
        end else begin
          $display("rsp txn: child %0d data %h", rsp_child, rsp_data);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_child = '0; req_data = '0;
    c_req_ready = '0; c_rsp_valid = '0; rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) child_data[i] = '0;
    tick();
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_child", rsp_child, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_err_bad", err_bad_idx, 0);
    check("reset_err_unexp", err_unexp_rsp, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single request to child 2
    c_req_ready = 5'b11111; rsp_ready = 1'b1;
    req_valid = 1'b1; req_child = 3'd2; req_data = 32'hA5;
    #1;
    check("t1_c_req_valid", c_req_valid, 5'b00100);
    check("t1_c_req_data", c_req_data, 32'hA5);
    check("t1_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("t1_cnt2", dut.cnt_q[2], 1);

    // Fill child 1, then free one slot with a response
    req_valid = 1'b1; req_child = 3'd1; req_data = 32'h11;
    for (int k = 0; k < 4; k++) begin
      check("t2_req_ready_fill", req_ready, 1);
      tick();
    end
    check("t2_req_ready_full", req_ready, 0);
    check("t2_c_req_valid_full", c_req_valid, 0);
    child_data[1] = 32'h1111_0001; c_rsp_valid = 5'b00010;
    #1;
    check("t2_c_rsp_ready", c_rsp_ready, 5'b00010);
    expect_rsp(1, 32'h1111_0001);
    tick();
    c_rsp_valid = '0;
    check("t2_req_ready_freed", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("t2_cnt1_refilled", dut.cnt_q[1], 4);
    tick();

    // Reset clears counters and pointer
    rst_n = 1'b0;
    #1;
    check("rst_cnt1", dut.cnt_q[1], 0);
    check("rst_cnt2", dut.cnt_q[2], 0);
    tick();
    rst_n = 1'b1;
    tick();

    // All children responding: RR sequence 0,1,2,3,4,0 back-to-back
    for (int i = 0; i < N; i++) child_data[i] = 32'hC0DE_0000 + DW'(i);
    c_rsp_valid = 5'b11111; rsp_ready = 1'b1;
    expect_rsp(0, 32'hC0DE_0000); expect_rsp(1, 32'hC0DE_0001); expect_rsp(2, 32'hC0DE_0002);
    expect_rsp(3, 32'hC0DE_0003); expect_rsp(4, 32'hC0DE_0004); expect_rsp(0, 32'hC0DE_0000);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t3_no_gap", rsp_valid, 1);
    end

    // Backpressure: hold output stable, no grants
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_c_rsp_ready_zero", c_rsp_ready, 0);
      tick();
      check("t4_hold_child", rsp_child, 0);
      check("t4_hold_data", rsp_data, 32'hC0DE_0000);
    end
    rsp_ready = 1'b1;
    #1;
    check("t4_release_grant", c_rsp_ready, 5'b00010);
    expect_rsp(1, 32'hC0DE_0001);
    tick();
    c_rsp_valid = '0;
    tick();
    check("t4_drained", rsp_valid, 0);

    // Bad index is consumed and flagged for one cycle
    req_valid = 1'b1; req_child = 3'd7; req_data = 32'hBAD;
    #1;
    check("t5_req_ready", req_ready, 1);
    check("t5_c_req_valid", c_req_valid, 0);
    tick();
    req_valid = 1'b0;
    check("t5_err_bad_pulse", err_bad_idx, 1);
    tick();
    check("t5_err_bad_clear", err_bad_idx, 0);

    // Unexpected response from child 3 is still forwarded
    child_data[3] = 32'h3333_0003; c_rsp_valid = 5'b01000;
    #1;
    check("t6_c_rsp_ready", c_rsp_ready, 5'b01000);
    expect_rsp(3, 32'h3333_0003);
    tick();
    c_rsp_valid = '0;
    check("t6_err_unexp_pulse", err_unexp_rsp, 1);
    check("t6_cnt3", dut.cnt_q[3], 0);
    tick();
    check("t6_err_unexp_clear", err_unexp_rsp, 0);

    // Mid-burst asynchronous reset
    rsp_ready = 1'b0; c_rsp_valid = 5'b11111;
    req_valid = 1'b1; req_child = 3'd0; req_data = 32'h5A;
    tick();
    req_valid = 1'b0;
    check("t7_loaded_valid", rsp_valid, 1);
    check("t7_loaded_child", rsp_child, 4);
    check("t7_cnt0", dut.cnt_q[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_async_rsp_valid", rsp_valid, 0);
    check("t7_async_rsp_data", rsp_data, 0);
    for (int i = 0; i < N; i++) check("t7_cnt_cleared", dut.cnt_q[i], 0);
    c_rsp_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
